// File: rtl/saturn_xfer_seq_pkg.sv
// Shared definitions for the Saturn data-pointer transfer sequencer: bus command codes,
// transfer directions and the sequencer state encoding.
package saturn_xfer_seq_pkg;

  typedef enum logic [3:0] {
    BusCmdNop     = 4'h0,
    BusCmdDpRead  = 4'h3,
    BusCmdDpWrite = 4'h5,
    BusCmdLoadPc  = 4'h6,
    BusCmdLoadDp  = 4'h7
  } bus_cmd_e;

  localparam logic TDirOut = 1'b0;
  localparam logic TDirIn  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadDp,
    StXfer,
    StRestore,
    StDone
  } xfer_state_e;

  function automatic bus_cmd_e xfer_cmd(input logic dir);
    return (dir == TDirOut) ? BusCmdDpWrite : BusCmdDpRead;
  endfunction

endpackage

// File: rtl/saturn_nibble_merge.sv
// Combinational nibble insert into one register image and nibble extract from another,
// both addressed by a register nibble index.
module saturn_nibble_merge #(
  parameter int unsigned NibW    = 4,
  parameter int unsigned RegNibs = 16,
  parameter int unsigned IdxW    = $clog2(RegNibs)
) (
  input  logic [NibW*RegNibs-1:0] ins_src_i,
  input  logic [IdxW-1:0]         ins_idx_i,
  input  logic [NibW-1:0]         ins_nib_i,
  input  logic                    ins_en_i,
  output logic [NibW*RegNibs-1:0] ins_data_o,
  input  logic [NibW*RegNibs-1:0] ext_src_i,
  input  logic [IdxW-1:0]         ext_idx_i,
  output logic [NibW-1:0]         ext_nib_o
);

  always_comb begin
    ins_data_o = ins_src_i;
    if (ins_en_i) begin
      ins_data_o[ins_idx_i*NibW +: NibW] = ins_nib_i;
    end
    ext_nib_o = ext_src_i[ext_idx_i*NibW +: NibW];
  end

endmodule

// File: rtl/saturn_xfer_seq.sv
// Sequences one multi-nibble DAT0/DAT1 transfer over the shared bus: LOAD_DP, N data
// commands, LOAD_PC; merges read nibbles into the latched register image.
module saturn_xfer_seq
  import saturn_xfer_seq_pkg::*;
#(
  parameter int unsigned NIB_W    = 4,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned REG_NIBS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_slot,
  input  logic                      xfer_start,
  input  logic                      xfer_dir,
  input  logic [ADDR_W-1:0]         xfer_addr,
  input  logic [3:0]                xfer_offset,
  input  logic [3:0]                xfer_cnt,
  input  logic [NIB_W*REG_NIBS-1:0] xfer_data,
  input  logic [ADDR_W-1:0]         pc,
  input  logic [NIB_W-1:0]          bus_nibble_out,
  input  logic                      bus_error,
  output logic [3:0]                bus_command,
  output logic [ADDR_W-1:0]         bus_address,
  output logic [NIB_W-1:0]          bus_nibble_in,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [NIB_W*REG_NIBS-1:0] rd_data
);

  localparam int unsigned RegW = NIB_W * REG_NIBS;

  xfer_state_e         state_q, state_d;
  bus_cmd_e            cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NIB_W-1:0]    nib_in_q, nib_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [RegW-1:0]     rd_data_q, rd_data_d;
  logic                dir_q, dir_d;
  logic [3:0]          offset_q, offset_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic [RegW-1:0]     data_q, data_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  // A DP_READ's nibble arrives with the following slot, so remember where it belongs.
  logic                cap_pend_q, cap_pend_d;
  logic [3:0]          cap_idx_q, cap_idx_d;

  logic                ins_en;
  logic [RegW-1:0]     ins_data;
  logic [3:0]          ext_idx;
  logic [NIB_W-1:0]    ext_nib;

  assign ext_idx = offset_q + ((state_q == StXfer) ? idx_q + 4'd1 : 4'd0);

  saturn_nibble_merge #(
    .NibW    (NIB_W),
    .RegNibs (REG_NIBS),
    .IdxW    (4)
  ) u_merge (
    .ins_src_i  (rd_data_q),
    .ins_idx_i  (cap_idx_q),
    .ins_nib_i  (bus_nibble_out),
    .ins_en_i   (ins_en),
    .ins_data_o (ins_data),
    .ext_src_i  (data_q),
    .ext_idx_i  (ext_idx),
    .ext_nib_o  (ext_nib)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    nib_in_d   = nib_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    rd_data_d  = ins_data;
    dir_d      = dir_q;
    offset_d   = offset_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    pc_d       = pc_q;
    cap_pend_d = cap_pend_q;
    cap_idx_d  = cap_idx_q;
    ins_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer_start) begin
          dir_d      = xfer_dir;
          offset_d   = xfer_offset;
          cnt_d      = xfer_cnt;
          data_d     = xfer_data;
          pc_d       = pc;
          rd_data_d  = xfer_data;
          cmd_d      = BusCmdLoadDp;
          addr_d     = xfer_addr;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          idx_d      = 4'd0;
          cap_pend_d = 1'b0;
          state_d    = StLoadDp;
        end
      end
      StLoadDp: begin
        if (bus_slot) begin
          if (bus_error) begin
            cmd_d   = BusCmdNop;
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cmd_d    = xfer_cmd(dir_q);
            nib_in_d = ext_nib;
            idx_d    = 4'd0;
            state_d  = StXfer;
          end
        end
      end
      StXfer: begin
        if (bus_slot) begin
          ins_en     = cap_pend_q;
          cap_pend_d = (dir_q == TDirIn);
          cap_idx_d  = offset_q + idx_q;
          if (bus_error) begin
            cap_pend_d = 1'b0;
            cmd_d      = BusCmdNop;
            error_d    = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = StDone;
          end else if (idx_q == cnt_q) begin
            cmd_d   = BusCmdLoadPc;
            addr_d  = pc_q;
            state_d = StRestore;
          end else begin
            idx_d    = idx_q + 4'd1;
            nib_in_d = ext_nib;
          end
        end
      end
      StRestore: begin
        if (bus_slot) begin
          ins_en     = cap_pend_q;
          cap_pend_d = 1'b0;
          cmd_d      = BusCmdNop;
          error_d    = error_q | bus_error;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= BusCmdNop;
      addr_q     <= '0;
      nib_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_data_q  <= '0;
      dir_q      <= 1'b0;
      offset_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      pc_q       <= '0;
      cap_pend_q <= 1'b0;
      cap_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      nib_in_q   <= nib_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_data_q  <= rd_data_d;
      dir_q      <= dir_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
      cap_pend_q <= cap_pend_d;
      cap_idx_q  <= cap_idx_d;
    end
  end

  assign bus_command   = cmd_q;
  assign bus_address   = addr_q;
  assign bus_nibble_in = nib_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_saturn_xfer_seq.sv
// Directed bench for saturn_xfer_seq: writes, wrapped reads, single nibble, bus abort,
// reset mid-transfer and sparse slots with an ignored start.
module tb_saturn_xfer_seq;
  import saturn_xfer_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_slot;
  logic        xfer_start;
  logic        xfer_dir;
  logic [19:0] xfer_addr;
  logic [3:0]  xfer_offset;
  logic [3:0]  xfer_cnt;
  logic [63:0] xfer_data;
  logic [19:0] pc;
  logic [3:0]  bus_nibble_out;
  logic        bus_error;
  logic [3:0]  bus_command;
  logic [19:0] bus_address;
  logic [3:0]  bus_nibble_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [63:0] rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  saturn_xfer_seq u_dut (
    .clk            (clk),
    .reset          (reset),
    .bus_slot       (bus_slot),
    .xfer_start     (xfer_start),
    .xfer_dir       (xfer_dir),
    .xfer_addr      (xfer_addr),
    .xfer_offset    (xfer_offset),
    .xfer_cnt       (xfer_cnt),
    .xfer_data      (xfer_data),
    .pc             (pc),
    .bus_nibble_out (bus_nibble_out),
    .bus_error      (bus_error),
    .bus_command    (bus_command),
    .bus_address    (bus_address),
    .bus_nibble_in  (bus_nibble_in),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rd_data        (rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the command waiting for this slot, then presents one slot with the given bus reply.
  task automatic slot(input string tag, input logic [3:0] cmd, input logic [19:0] adr,
                      input logic [3:0] wnib, input logic [3:0] ret, input logic err,
                      input int gap);
    chk({tag, " cmd"}, {60'd0, bus_command}, {60'd0, cmd});
    chk({tag, " busy"}, {63'd0, busy}, 64'd1);
    if (cmd == BusCmdLoadDp || cmd == BusCmdLoadPc)
      chk({tag, " addr"}, {44'd0, bus_address}, {44'd0, adr});
    if (cmd == BusCmdDpWrite)
      chk({tag, " wnib"}, {60'd0, bus_nibble_in}, {60'd0, wnib});
    bus_slot       = 1'b1;
    bus_nibble_out = ret;
    bus_error      = err;
    @(negedge clk);
    bus_slot  = 1'b0;
    bus_error = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start(input string tag, input logic dir, input logic [19:0] adr,
                       input logic [3:0] off, input logic [3:0] cnt, input logic [63:0] data,
                       input logic [19:0] p, input logic with_slot);
    xfer_dir    = dir;
    xfer_addr   = adr;
    xfer_offset = off;
    xfer_cnt    = cnt;
    xfer_data   = data;
    pc          = p;
    xfer_start  = 1'b1;
    bus_slot    = with_slot;
    @(negedge clk);
    xfer_start = 1'b0;
    bus_slot   = 1'b0;
    // Scramble inputs so only latched values can produce the expected sequence.
    xfer_addr   = ~adr;
    xfer_offset = ~off;
    xfer_cnt    = ~cnt;
    xfer_data   = ~data;
    pc          = ~p;
    chk({tag, " start busy"}, {63'd0, busy}, 64'd1);
    chk({tag, " start err"}, {63'd0, error}, 64'd0);
    chk({tag, " start done"}, {63'd0, done}, 64'd0);
  endtask

  task automatic fin(input string tag, input logic exp_err, input logic [63:0] exp_rd);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " cmd"}, {60'd0, bus_command}, {60'd0, BusCmdNop});
    chk({tag, " err"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, " rd"}, rd_data, exp_rd);
    @(negedge clk);
    chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
    chk({tag, " cmd hold"}, {60'd0, bus_command}, {60'd0, BusCmdNop});
  endtask

  initial begin
    reset          = 1'b1;
    bus_slot       = 1'b0;
    xfer_start     = 1'b0;
    xfer_dir       = 1'b0;
    xfer_addr      = '0;
    xfer_offset    = '0;
    xfer_cnt       = '0;
    xfer_data      = '0;
    pc             = '0;
    bus_nibble_out = '0;
    bus_error      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst cmd", {60'd0, bus_command}, 64'd0);
    chk("rst addr", {44'd0, bus_address}, 64'd0);
    chk("rst wnib", {60'd0, bus_nibble_in}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst err", {63'd0, error}, 64'd0);
    chk("rst rd", rd_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write A field: E, D, C, B, A then LOAD_PC; 7 slots.
    start("wr", 1'b0, 20'h80000, 4'd0, 4'd4, 64'h0000_0000_000A_BCDE, 20'h00123, 1'b0);
    slot("wr ld", BusCmdLoadDp, 20'h80000, 4'h0, 4'h0, 1'b0, 0);
    slot("wr n0", BusCmdDpWrite, 20'h0, 4'hE, 4'h0, 1'b0, 0);
    slot("wr n1", BusCmdDpWrite, 20'h0, 4'hD, 4'h0, 1'b0, 0);
    slot("wr n2", BusCmdDpWrite, 20'h0, 4'hC, 4'h0, 1'b0, 0);
    slot("wr n3", BusCmdDpWrite, 20'h0, 4'hB, 4'h0, 1'b0, 0);
    slot("wr n4", BusCmdDpWrite, 20'h0, 4'hA, 4'h0, 1'b0, 0);
    slot("wr pc", BusCmdLoadPc, 20'h00123, 4'h0, 4'h0, 1'b0, 0);
    fin("wr", 1'b0, 64'h0000_0000_000A_BCDE);

    // Read with index wrap: nibbles 14, 15, 0, 1; each reply arrives on the next slot.
    start("rdw", 1'b1, 20'h01000, 4'd14, 4'd3, 64'd0, 20'h00200, 1'b0);
    slot("rdw ld", BusCmdLoadDp, 20'h01000, 4'h0, 4'h0, 1'b0, 0);
    slot("rdw r0", BusCmdDpRead, 20'h0, 4'h0, 4'h0, 1'b0, 0);
    slot("rdw r1", BusCmdDpRead, 20'h0, 4'h0, 4'h1, 1'b0, 0);
    slot("rdw r2", BusCmdDpRead, 20'h0, 4'h0, 4'h2, 1'b0, 0);
    slot("rdw r3", BusCmdDpRead, 20'h0, 4'h0, 4'h3, 1'b0, 0);
    slot("rdw pc", BusCmdLoadPc, 20'h00200, 4'h0, 4'h4, 1'b0, 0);
    fin("rdw", 1'b0, 64'h2100_0000_0000_0043);

    // Single nibble read at index 5; the slot coinciding with start is not used.
    start("p", 1'b1, 20'h02000, 4'd5, 4'd0, 64'h1111_1111_1111_1111, 20'h00300, 1'b1);
    slot("p ld", BusCmdLoadDp, 20'h02000, 4'h0, 4'h0, 1'b0, 0);
    slot("p r0", BusCmdDpRead, 20'h0, 4'h0, 4'h0, 1'b0, 0);
    slot("p pc", BusCmdLoadPc, 20'h00300, 4'h0, 4'hF, 1'b0, 0);
    fin("p", 1'b0, 64'h1111_1111_11F1_1111);

    // Bus error on the third of eight reads: two nibbles kept, no LOAD_PC.
    start("be", 1'b1, 20'h03000, 4'd0, 4'd7, 64'd0, 20'h00400, 1'b0);
    slot("be ld", BusCmdLoadDp, 20'h03000, 4'h0, 4'h0, 1'b0, 0);
    slot("be r0", BusCmdDpRead, 20'h0, 4'h0, 4'h0, 1'b0, 0);
    slot("be r1", BusCmdDpRead, 20'h0, 4'h0, 4'hA, 1'b0, 0);
    slot("be r2", BusCmdDpRead, 20'h0, 4'h0, 4'hB, 1'b1, 0);
    fin("be", 1'b1, 64'h0000_0000_0000_00BA);
    @(negedge clk);
    chk("be sticky", {63'd0, error}, 64'd1);
    chk("be no pc", {60'd0, bus_command}, {60'd0, BusCmdNop});
    start("clr", 1'b0, 20'h03100, 4'd0, 4'd0, 64'h0000_0000_0000_0007, 20'h00410, 1'b0);
    slot("clr ld", BusCmdLoadDp, 20'h03100, 4'h0, 4'h0, 1'b0, 0);
    slot("clr w0", BusCmdDpWrite, 20'h0, 4'h7, 4'h0, 1'b0, 0);
    slot("clr pc", BusCmdLoadPc, 20'h00410, 4'h0, 4'h0, 1'b0, 0);
    fin("clr", 1'b0, 64'h0000_0000_0000_0007);

    // Reset in the middle of the data phase.
    start("rs", 1'b0, 20'h04000, 4'd2, 4'd3, 64'h0000_0000_0000_0900, 20'h00500, 1'b0);
    slot("rs ld", BusCmdLoadDp, 20'h04000, 4'h0, 4'h0, 1'b0, 0);
    slot("rs w0", BusCmdDpWrite, 20'h0, 4'h9, 4'h0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs cmd", {60'd0, bus_command}, {60'd0, BusCmdNop});
    chk("rs busy", {63'd0, busy}, 64'd0);
    chk("rs done", {63'd0, done}, 64'd0);
    chk("rs rd", rd_data, 64'd0);
    @(negedge clk);

    // Sparse slots (every 4 clks) with a stray start while busy.
    start("sp", 1'b0, 20'h80000, 4'd0, 4'd4, 64'h0000_0000_000A_BCDE, 20'h00123, 1'b0);
    slot("sp ld", BusCmdLoadDp, 20'h80000, 4'h0, 4'h0, 1'b0, 3);
    slot("sp n0", BusCmdDpWrite, 20'h0, 4'hE, 4'h0, 1'b0, 0);
    xfer_dir   = 1'b1;
    xfer_start = 1'b1;
    @(negedge clk);
    xfer_start = 1'b0;
    repeat (2) @(negedge clk);
    slot("sp n1", BusCmdDpWrite, 20'h0, 4'hD, 4'h0, 1'b0, 3);
    slot("sp n2", BusCmdDpWrite, 20'h0, 4'hC, 4'h0, 1'b0, 3);
    slot("sp n3", BusCmdDpWrite, 20'h0, 4'hB, 4'h0, 1'b0, 3);
    slot("sp n4", BusCmdDpWrite, 20'h0, 4'hA, 4'h0, 1'b0, 3);
    slot("sp pc", BusCmdLoadPc, 20'h00123, 4'h0, 4'h0, 1'b0, 0);
    fin("sp", 1'b0, 64'h0000_0000_000A_BCDE);
    @(negedge clk);
    chk("sp idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
